// File: rtl/pixel_stream_source_pkg.sv
// rtl/pixel_stream_source_pkg.sv - state encoding and width helper shared by the raster streamer and edge writer
package pixel_stream_source_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LINE  = 2'd1,
        ST_BLANK = 2'd2,
        ST_DRAIN = 2'd3
    } stream_state_e;

    // Never returns less than 1 so a degenerate dimension still gets a real bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pixel_stream_source_raster_counter.sv
// rtl/pixel_stream_source_raster_counter.sv - column/row/linear-address counters with end-of-line and end-of-frame flags
module raster_counter
    import pixel_stream_source_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int ADDR_W     = 19,
    parameter int COL_W      = clog2(IMG_WIDTH),
    parameter int ROW_W      = clog2(IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              last_col,
    output logic              last_row
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);
    assign col      = col_q;
    assign row      = row_q;
    assign addr     = addr_q;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clear) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (advance) begin
            if (last_col) begin
                col_d = '0;
                if (!last_row) begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
            // Parks on the final pixel address instead of stepping past the frame.
            if (!(last_col && last_row)) begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/pixel_stream_source.sv
// rtl/pixel_stream_source.sv - raster frame streamer with line gaps; PIXEL_SOURCE_TEST_PATTERN_EN adds a (col+row) test pattern
module pixel_stream_source
    import pixel_stream_source_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int HBLANK     = 4,
    parameter int ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef PIXEL_SOURCE_TEST_PATTERN_EN
    input  logic              pattern_sel,
`endif
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic              valid_out,
    output logic [PIX_W-1:0]  pixel_data,
    output logic              sof,
    output logic              eol,
    output logic              busy,
    output logic              frame_done
);

    localparam int COL_W = clog2(IMG_WIDTH);
    localparam int ROW_W = clog2(IMG_HEIGHT);
    localparam int GAP_W = clog2(HBLANK + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((HBLANK > 0) ? HBLANK - 1 : 0);

    stream_state_e    state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             rd_en_q, rd_en_d;
    logic             a_vld_q, a_vld_d, a_first_q, a_first_d, a_last_q, a_last_d;
    logic             valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
    logic [PIX_W-1:0] pixel_q, pixel_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             accept, clear, advance, pattern_next;
    logic [PIX_W-1:0] stage_b_data;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             last_col, last_row;

    // A start landing on the frame_done cycle is dropped, not queued.
    assign accept = (state_q == ST_IDLE) && start && !done_q;

    raster_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .ADDR_W     (ADDR_W),
        .COL_W      (COL_W),
        .ROW_W      (ROW_W)
    ) u_raster_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .advance  (advance),
        .col      (col),
        .row      (row),
        .addr     (mem_rd_addr),
        .last_col (last_col),
        .last_row (last_row)
    );

`ifdef PIXEL_SOURCE_TEST_PATTERN_EN
    logic             pat_q, pat_d;
    logic [PIX_W-1:0] a_pat_q, a_pat_d;

    always_comb begin
        pat_d   = accept ? pattern_sel : pat_q;
        a_pat_d = PIX_W'(32'(col) + 32'(row));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q   <= 1'b0;
            a_pat_q <= '0;
        end else begin
            pat_q   <= pat_d;
            a_pat_q <= a_pat_d;
        end
    end

    assign pattern_next = pat_d;
    assign stage_b_data = pat_q ? a_pat_q : mem_rd_data;
`else
    assign pattern_next = 1'b0;
    assign stage_b_data = mem_rd_data;
`endif

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        clear   = 1'b0;
        advance = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LINE;
                    clear   = 1'b1;
                end
            end
            ST_LINE: begin
                advance = 1'b1;
                if (last_col) begin
                    if (last_row) begin
                        state_d = ST_DRAIN;
                    end else if (HBLANK > 0) begin
                        state_d = ST_BLANK;
                        gap_d   = '0;
                    end
                end
            end
            ST_BLANK: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_LINE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_DRAIN: begin
                // Stage A empty means stage B is presenting the final pixel now.
                if (!a_vld_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rd_en_d   = (state_d == ST_LINE) && !pattern_next;
        busy_d    = (state_d != ST_IDLE) || done_d;

        a_vld_d   = (state_q == ST_LINE);
        a_first_d = (state_q == ST_LINE) && (col == '0) && (row == '0);
        a_last_d  = (state_q == ST_LINE) && last_col;

        valid_d   = a_vld_q;
        sof_d     = a_vld_q && a_first_q;
        eol_d     = a_vld_q && a_last_q;
        pixel_d   = a_vld_q ? stage_b_data : pixel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gap_q     <= '0;
            rd_en_q   <= 1'b0;
            a_vld_q   <= 1'b0;
            a_first_q <= 1'b0;
            a_last_q  <= 1'b0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            pixel_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            rd_en_q   <= rd_en_d;
            a_vld_q   <= a_vld_d;
            a_first_q <= a_first_d;
            a_last_q  <= a_last_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            pixel_q   <= pixel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign mem_rd_en  = rd_en_q;
    assign valid_out  = valid_q;
    assign pixel_data = pixel_q;
    assign sof        = sof_q;
    assign eol        = eol_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: doc/pixel_stream_source.md
Name: pixel_stream_source

Overview:
- Raster pixel streamer that reads an 8-bit grayscale frame from a synchronous-read frame memory.
- Emits the frame as a valid-qualified pixel stream, row-major, top-left first, for the edge-detection pipeline's `valid_in`/`pixel_data` inputs.
- Inserts a programmable horizontal gap after each line, marks start-of-frame and end-of-line, and reports frame completion to the control logic.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=2).
- IMG_HEIGHT, 480, lines per frame (>=1).
- HBLANK, 4, idle cycles inserted after every line except the last (0 allowed).
- ADDR_W, 19, frame-memory address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- mem_rd_en  out  1  frame-memory read strobe
- mem_rd_addr  out  ADDR_W  linear pixel address, row*IMG_WIDTH+col
- mem_rd_data  in  8  read data, valid exactly one cycle after mem_rd_en
- valid_out  out  1  pixel_data valid this cycle
- pixel_data  out  8  streamed pixel
- sof  out  1  high with the first pixel of a frame
- eol  out  1  high with the last pixel of each line
- busy  out  1  frame in progress, including pipeline drain
- frame_done  out  1  one-cycle pulse after the last pixel

Behaviour:
- Reset (async, rst_n low): all outputs 0; state IDLE; row/col/address counters 0; read pipeline flags cleared. Reset mid-frame abandons the frame immediately; no frame_done is produced.
- States: IDLE, LINE, BLANK, DRAIN.
  - IDLE: start=1 -> LINE; col=0, row=0, addr=0.
  - LINE: mem_rd_en=1 and mem_rd_addr=addr every cycle; col++ and addr++.
    - At col=IMG_WIDTH-1 with row<IMG_HEIGHT-1: row++, col=0, then BLANK (or stay in LINE if HBLANK=0).
    - At col=IMG_WIDTH-1 with row=IMG_HEIGHT-1: go to DRAIN.
  - BLANK: mem_rd_en=0; gap counter counts HBLANK cycles, then LINE.
  - DRAIN: wait for the 2-stage read pipeline to empty, assert frame_done for one cycle, then IDLE.
- Read pipeline:
  - Stage A registers the rd_en/first/last-col flags alongside the memory access.
  - Stage B registers mem_rd_data into pixel_data and sets valid_out/sof/eol.
  - Latency: valid_out rises 2 cycles after its mem_rd_en.
  - start at cycle 0 -> mem_rd_en at cycle 1 -> first valid_out at cycle 3.
- pixel_data holds its last value when valid_out=0. sof and eol are 0 whenever valid_out=0.
- busy = 1 from the cycle after start is accepted through the frame_done cycle inclusive.
- start while busy is ignored; no queuing. start coincident with frame_done is also ignored.
- Address is a separate incrementing counter (no multiplier); it never exceeds IMG_WIDTH*IMG_HEIGHT-1. Row/col counters are sized with clog2 of the respective parameter.
- Frame length: IMG_WIDTH*IMG_HEIGHT valid cycles plus (IMG_HEIGHT-1)*HBLANK gap cycles.
- IMG_HEIGHT=1: no BLANK state is ever entered.

Optional Feature:
- Macro: PIXEL_SOURCE_TEST_PATTERN_EN.
- Defined:
  - Adds input `pattern_sel` (1 bit), sampled at start.
  - pattern_sel=1 replaces memory data with (col+row)[7:0]. Timing, sof/eol and frame_done are identical to memory mode; mem_rd_en stays 0 for the whole frame.
  - pattern_sel=0 behaves as memory mode.
- Undefined: no pattern_sel port and no pattern logic; memory mode only.

Decomposition:
- Shared package: state encoding constants (IDLE/LINE/BLANK/DRAIN) and a clog2 constant function, both reused by the downstream edge writer.
- One natural sub-module: raster_counter (col/row/addr counters plus last-col/last-row flags), instantiated once. Remaining FSM and pipeline stay in the top.

Test Plan:
- Params 4x3, HBLANK=2, memory preloaded with value=addr. Pulse start -> 12 valid pixels 0..11 in order; two 2-cycle gaps after pixels 3 and 7; first valid at cycle 3; frame_done one cycle after pixel 11; busy low afterwards.
- Same frame -> sof only with pixel 0; eol with pixels 3, 7, 11; mem_rd_addr sequence 0..11 with no repeats.
- Start pulsed at cycles 5 and 10 mid-frame -> exactly one frame produced; start on the frame_done cycle ignored.
- HBLANK=0 -> 12 contiguous valid cycles; IMG_HEIGHT=1 -> 4 pixels then frame_done, no gap.
- rst_n asserted after pixel 5 -> all outputs 0 immediately, no frame_done; next start restarts from addr 0 with sof.
- PIXEL_SOURCE_TEST_PATTERN_EN defined, pattern_sel=1 -> pixels 0,1,2,3,1,2,3,4,2,3,4,5; mem_rd_en never high.
